// File: rtl/wb_stage_multi_pkg.sv
// Shared widths, per-lane field offsets and FSM encodings for the multi-lane writeback stage.
// The optional commit trace is built only when WB_TRACE_EN is defined.
package wb_stage_multi_pkg;

  localparam int MAX_LANES = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  // Lane input layout, MSB first: {csr_we, csr_waddr, csr_wdata, regs_we, regs_waddr, regs_wdata}
  function automatic int lane_in_w(int ra_w, int dw, int csra_w);
    return 2 + csra_w + ra_w + 2 * dw;
  endfunction

  function automatic int off_regs_we(int ra_w, int dw);
    return dw + ra_w;
  endfunction

  function automatic int off_csr_wdata(int ra_w, int dw);
    return dw + ra_w + 1;
  endfunction

  function automatic int off_csr_waddr(int ra_w, int dw);
    return 2 * dw + ra_w + 1;
  endfunction

  function automatic int lane_out_w(int ra_w, int dw);
    return 1 + ra_w + dw;
  endfunction

  function automatic int trace_lane_w(int pc_w, int ra_w, int dw);
    return 2 + pc_w + ra_w + dw;
  endfunction

  function automatic logic [2:0] popcnt4(logic [MAX_LANES-1:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/wb_stage_multi_if.sv
// MEM->WB->RFB bus bundle for wb_stage_multi; trace signals exist only with WB_TRACE_EN.
interface wb_stage_multi_if
  import wb_stage_multi_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int RA_W   = 5,
  parameter int DW     = 32,
  parameter int CSRA_W = 14
) ();

  logic                                          mw_valid_i;
  logic                                          wb_allowin_o;
  logic [LANES-1:0]                              mw_lane_valid_i;
  logic [LANES*lane_in_w(RA_W, DW, CSRA_W)-1:0]  mw_to_ibus;
  logic [LANES*(PC_W+INST_W)-1:0]                pc_inst_ibus;
  logic                                          flush_i;
  logic                                          rfb_allowin_i;
  logic                                          wb_to_rfb_valid_o;
  logic [LANES*(PC_W+INST_W)-1:0]                pc_inst_obus;
  logic [LANES*lane_out_w(RA_W, DW)-1:0]         to_regs_obus;
  logic [CSRA_W+DW:0]                            to_csr_obus;
`ifdef WB_TRACE_EN
  logic [63:0]                                   commit_cnt_o;
  logic [LANES*trace_lane_w(PC_W, RA_W, DW)-1:0] trace_obus;
`endif

  modport slave (
    input  mw_valid_i, mw_lane_valid_i, mw_to_ibus, pc_inst_ibus, flush_i, rfb_allowin_i,
    output wb_allowin_o, wb_to_rfb_valid_o, pc_inst_obus, to_regs_obus, to_csr_obus
`ifdef WB_TRACE_EN
    , commit_cnt_o, trace_obus
`endif
  );

  modport master (
    output mw_valid_i, mw_lane_valid_i, mw_to_ibus, pc_inst_ibus, flush_i, rfb_allowin_i,
    input  wb_allowin_o, wb_to_rfb_valid_o, pc_inst_obus, to_regs_obus, to_csr_obus
`ifdef WB_TRACE_EN
    , commit_cnt_o, trace_obus
`endif
  );

endinterface

// File: rtl/wb_stage_multi_csr_serializer.sv
// Serialises the CSR writes of one WB bundle onto a single CSR port, oldest lane first.
//   state   | meaning
//   IDLE    | at most one CSR write pending; bundle may commit (ready_go=1)
//   SEQ     | two or more CSR writes pending; bundle stalls while one issues per cycle
module wb_stage_multi_csr_serializer
  import wb_stage_multi_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int CSRA_W = 14,
  parameter int DW     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_capture,
  input  logic [LANES-1:0]             i_new_pend,
  input  logic                         i_wb_valid,
  input  logic                         i_flush,
  input  logic                         i_retire,
  input  logic [LANES-1:0][CSRA_W-1:0] i_csr_waddr,
  input  logic [LANES-1:0][DW-1:0]     i_csr_wdata,
  output logic                         o_ready_go,
  output logic                         o_csr_we,
  output logic [CSRA_W-1:0]            o_csr_waddr,
  output logic [DW-1:0]                o_csr_wdata
);

  logic [0:0]       r_state;
  logic [LANES-1:0] r_csr_pend;
  logic [LANES-1:0] w_pend_next;
  logic [LANES-1:0] w_low;
  logic             w_issue;

  assign w_low      = r_csr_pend & (~r_csr_pend + LANES'(1));
  assign w_issue    = i_wb_valid & (|r_csr_pend) & ~i_flush;
  assign o_ready_go = (r_state == ST_IDLE);
  assign o_csr_we   = w_issue;

  always_comb begin
    o_csr_waddr = '0;
    o_csr_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_low[i]) begin
        o_csr_waddr = i_csr_waddr[i];
        o_csr_wdata = i_csr_wdata[i];
      end
    end
  end

  // The final write stays pending (and repeats) until the bundle actually retires.
  always_comb begin
    w_pend_next = r_csr_pend;
    if (i_capture) begin
      w_pend_next = i_new_pend;
    end else if (i_flush) begin
      w_pend_next = '0;
    end else if (w_issue && ((r_state == ST_SEQ) || i_retire)) begin
      w_pend_next = r_csr_pend & ~w_low;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csr_pend <= '0;
      r_state    <= ST_IDLE;
    end else begin
      r_csr_pend <= w_pend_next;
      r_state    <= (popcnt4(MAX_LANES'(w_pend_next)) > 3'd1) ? ST_SEQ : ST_IDLE;
    end
  end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: MEM->WB register, youngest-wins GPR commit, serialised CSR port.
// Define WB_TRACE_EN to add commit_cnt_o and the per-lane trace_obus.
module wb_stage_multi
  import wb_stage_multi_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int RA_W   = 5,
  parameter int DW     = 32,
  parameter int CSRA_W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_stage_multi_if.slave bus
);

  localparam int LIN_W  = lane_in_w(RA_W, DW, CSRA_W);
  localparam int LOUT_W = lane_out_w(RA_W, DW);
  localparam int PI_W   = PC_W + INST_W;

  logic [LANES-1:0]             w_in_csr_we;
  logic [LANES-1:0][CSRA_W-1:0] w_in_csr_waddr;
  logic [LANES-1:0][DW-1:0]     w_in_csr_wdata;
  logic [LANES-1:0]             w_in_regs_we;
  logic [LANES-1:0][RA_W-1:0]   w_in_regs_waddr;
  logic [LANES-1:0][DW-1:0]     w_in_regs_wdata;

  logic                         r_wb_valid;
  logic [LANES-1:0]             r_lane_valid;
  logic [LANES-1:0][CSRA_W-1:0] r_csr_waddr;
  logic [LANES-1:0][DW-1:0]     r_csr_wdata;
  logic [LANES-1:0]             r_regs_we;
  logic [LANES-1:0][RA_W-1:0]   r_regs_waddr;
  logic [LANES-1:0][DW-1:0]     r_regs_wdata;
  logic [LANES*PI_W-1:0]        r_pc_inst;

  logic                         w_ready_go;
  logic                         w_commit;
  logic                         w_retire;
  logic                         w_allowin;
  logic                         w_capture;
  logic                         w_csr_we;
  logic [CSRA_W-1:0]            w_csr_waddr;
  logic [DW-1:0]                w_csr_wdata;
  logic [LANES-1:0]             w_wr_req;
  logic [LANES-1:0]             w_shadowed;
  logic [LANES-1:0]             w_regs_we;
  logic [LANES-1:0][LOUT_W-1:0] w_regs_o;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int B = g * LIN_W;
    assign w_in_regs_wdata[g] = bus.mw_to_ibus[B +: DW];
    assign w_in_regs_waddr[g] = bus.mw_to_ibus[B + DW +: RA_W];
    assign w_in_regs_we[g]    = bus.mw_to_ibus[B + off_regs_we(RA_W, DW)];
    assign w_in_csr_wdata[g]  = bus.mw_to_ibus[B + off_csr_wdata(RA_W, DW) +: DW];
    assign w_in_csr_waddr[g]  = bus.mw_to_ibus[B + off_csr_waddr(RA_W, DW) +: CSRA_W];
    assign w_in_csr_we[g]     = bus.mw_to_ibus[B + LIN_W - 1];

    assign w_wr_req[g]  = r_lane_valid[g] & r_regs_we[g] & (r_regs_waddr[g] != '0);
    assign w_regs_we[g] = w_retire & w_wr_req[g] & ~w_shadowed[g];
    assign w_regs_o[g]  = {w_regs_we[g], r_regs_waddr[g], r_regs_wdata[g]};
  end

  // A younger lane writing the same GPR supersedes the older one.
  always_comb begin
    w_shadowed = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_wr_req[j] && (r_regs_waddr[j] == r_regs_waddr[i])) begin
          w_shadowed[i] = 1'b1;
        end
      end
    end
  end

  assign w_commit  = r_wb_valid & w_ready_go & ~bus.flush_i;
  assign w_retire  = w_commit & bus.rfb_allowin_i;
  assign w_allowin = ~r_wb_valid | (w_ready_go & bus.rfb_allowin_i);
  assign w_capture = bus.mw_valid_i & w_allowin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid   <= 1'b0;
      r_lane_valid <= '0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_regs_we    <= '0;
      r_regs_waddr <= '0;
      r_regs_wdata <= '0;
      r_pc_inst    <= '0;
    end else if (w_capture) begin
      r_wb_valid   <= 1'b1;
      r_lane_valid <= bus.mw_lane_valid_i;
      r_csr_waddr  <= w_in_csr_waddr;
      r_csr_wdata  <= w_in_csr_wdata;
      r_regs_we    <= w_in_regs_we;
      r_regs_waddr <= w_in_regs_waddr;
      r_regs_wdata <= w_in_regs_wdata;
      r_pc_inst    <= bus.pc_inst_ibus;
    end else if (bus.flush_i || w_retire) begin
      r_wb_valid   <= 1'b0;
    end
  end

  wb_stage_multi_csr_serializer #(
    .LANES  (LANES),
    .CSRA_W (CSRA_W),
    .DW     (DW)
  ) u_csr_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_capture   (w_capture),
    .i_new_pend  (w_in_csr_we & bus.mw_lane_valid_i),
    .i_wb_valid  (r_wb_valid),
    .i_flush     (bus.flush_i),
    .i_retire    (w_retire),
    .i_csr_waddr (r_csr_waddr),
    .i_csr_wdata (r_csr_wdata),
    .o_ready_go  (w_ready_go),
    .o_csr_we    (w_csr_we),
    .o_csr_waddr (w_csr_waddr),
    .o_csr_wdata (w_csr_wdata)
  );

  assign bus.wb_allowin_o      = w_allowin;
  assign bus.wb_to_rfb_valid_o = w_commit;
  assign bus.pc_inst_obus      = r_pc_inst;
  assign bus.to_regs_obus      = w_regs_o;
  assign bus.to_csr_obus       = {w_csr_we, w_csr_waddr, w_csr_wdata};

`ifdef WB_TRACE_EN
  localparam int TR_W = trace_lane_w(PC_W, RA_W, DW);

  logic [63:0]                r_commit_cnt;
  logic [LANES-1:0][TR_W-1:0] w_trace;

  for (genvar g = 0; g < LANES; g++) begin : g_trace
    assign w_trace[g] = {w_retire & r_lane_valid[g], r_pc_inst[g*PI_W + INST_W +: PC_W], w_regs_o[g]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_cnt <= '0;
    end else if (w_retire) begin
      r_commit_cnt <= r_commit_cnt + 64'(popcnt4(MAX_LANES'(r_lane_valid)));
    end
  end

  assign bus.commit_cnt_o = r_commit_cnt;
  assign bus.trace_obus   = w_trace;
`endif

endmodule
